// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: zero-latency IF lookup, EX-stage training and mispredict redirect.
// Optional performance counters are compiled in with `define BPRED_PERF_EN.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 2 ** (CTR_W - 1)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_uncond,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_npc,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  input  logic        flush_all,
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_NEW = CTR_W'(CTR_INIT);

  logic [ENTRIES-1:0]            valid;
  logic [ENTRIES-1:0][TAG_W-1:0] tag;
  logic [ENTRIES-1:0][31:0]      target;
  logic [ENTRIES-1:0][CTR_W-1:0] ctr;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic [31:0]      actual;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];

  assign l_hit      = valid[l_idx] && (tag[l_idx] == l_tag);
  assign u_hit      = valid[u_idx] && (tag[u_idx] == u_tag);
  assign pred_taken = l_hit && ctr[l_idx][CTR_W-1];
  assign pred_npc   = pred_taken ? target[l_idx] : lookup_pc + 32'd4;

  // Resolution compares against the carried next-PC, so a correct-target
  // taken prediction and a correct fall-through are both non-events.
  assign actual      = upd_taken ? upd_target : upd_pc + 32'd4;
  assign mispredict  = upd_en && (actual != ex_pred_npc);
  assign redirect_pc = upd_en ? actual : 32'd0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid  <= '0;
      tag    <= '0;
      target <= '0;
      ctr    <= '0;
    end else if (flush_all) begin
      valid <= '0;
    end else if (upd_en) begin
      if (u_hit) begin
        if (upd_uncond) begin
          ctr[u_idx]    <= CTR_MAX;
          target[u_idx] <= upd_target;
        end else if (upd_taken) begin
          if (ctr[u_idx] != CTR_MAX) ctr[u_idx] <= ctr[u_idx] + 1'b1;
          target[u_idx] <= upd_target;
        end else if (ctr[u_idx] != '0) begin
          ctr[u_idx] <= ctr[u_idx] - 1'b1;
        end
      end else if (upd_taken || upd_uncond) begin
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= u_tag;
        target[u_idx] <= upd_target;
        ctr[u_idx]    <= upd_uncond ? CTR_MAX : CTR_NEW;
      end
    end
  end

`ifdef BPRED_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_lookups     <= '0;
      perf_mispredicts <= '0;
    end else begin
      perf_lookups <= perf_lookups + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`else
  assign perf_lookups     = 32'd0;
  assign perf_mispredicts = 32'd0;
`endif

  // Word-offset bits and the carried direction bit play no part in lookup or resolution.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], ex_pred_taken};
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised direct-mapped branch target buffer (BTB) with saturating direction counters for the pipelined MIPS datapath.
- Predicts the next fetch PC in IF, so taken branches and jumps no longer wait for EX resolution.
- Trains from the EX stage, compares each prediction with the resolved outcome, and drives the mispredict redirect that replaces the always-not-taken flush.

Parameters:
ENTRIES, 16, number of BTB entries; power of 2, at least 2; IDX_W = log2(ENTRIES)
CTR_W, 2, direction counter width, 1..4
CTR_INIT, 2**(CTR_W-1), counter value written when a new entry is allocated by a taken conditional branch (weakly taken)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
lookup_pc  in  32  IF-stage PC
pred_taken  out  1  prediction for lookup_pc is taken
pred_npc  out  32  predicted next fetch PC
upd_en  in  1  EX stage resolves a branch or jump this cycle; the datapath pulses it for exactly one cycle per instruction
upd_pc  in  32  PC of the resolving instruction
upd_taken  in  1  resolved direction
upd_target  in  32  resolved target
upd_uncond  in  1  instruction is j, jal or jr
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pred_npc  in  32  predicted next PC carried down the pipe with the instruction
mispredict  out  1  pipeline must flush IF/ID and ID/EX
redirect_pc  out  32  correct next PC, valid when mispredict is 1
flush_all  in  1  synchronous invalidate of every entry
perf_lookups  out  32  performance counter (see Optional Feature)
perf_mispredicts  out  32  performance counter (see Optional Feature)

Behaviour:
- Clocking and reset: one clock domain, CLK. Reset is asynchronous and active-low on nRST.
- Entry contents: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[CTR_W-1:0]. Index = pc[IDX_W+1:2].
- Reset: all valid = 0, all ctr = 0, all targets = 0. An assertion mid-operation clears state immediately; pending updates are lost.
- Lookup (combinational, zero latency):
  - hit = valid[idx] and tag match.
  - pred_taken = hit and ctr[CTR_W-1].
  - pred_npc = pred_taken ? target : lookup_pc+4, computed modulo 2^32 (0xFFFFFFFC+4 = 0).
  - After reset: pred_taken = 0 and pred_npc = lookup_pc+4.
- Mispredict (combinational, asserted only while upd_en = 1):
  - actual = upd_taken ? upd_target : upd_pc+4.
  - mispredict = upd_en and (actual != ex_pred_npc).
  - redirect_pc = actual. It is 0 whenever upd_en = 0.
- Update on the rising edge when upd_en = 1:
  - Hit, conditional branch: taken increments ctr, saturating at 2^CTR_W-1; not taken decrements ctr, saturating at 0. If taken, target = upd_target.
  - Hit, unconditional: ctr = max, target = upd_target.
  - Miss, taken or unconditional: allocate and overwrite the slot. valid = 1, tag and target written, ctr = max if unconditional, else CTR_INIT.
  - Miss, not taken: no change.
- Same-cycle lookup and update of the same index: the lookup sees pre-edge contents. The write becomes visible on the next cycle.
- flush_all = 1 at an edge clears every valid bit and takes priority over a simultaneous update. Counters and targets are retained but unused.
- No internal stall input: the datapath must not pulse upd_en twice for one instruction while EX is stalled.

Optional Feature:
- Macro BPRED_PERF_EN.
- Defined:
  - perf_lookups increments on every edge where nRST = 1.
  - perf_mispredicts increments on every edge where mispredict = 1.
  - Both counters are 32-bit, wrap to 0 after 0xFFFFFFFF, reset to 0, and are unaffected by flush_all.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
1. Reset, then lookup_pc = 0x00000040 -> pred_taken = 0, pred_npc = 0x00000044. Update with ex_pred_npc = 0x44, upd_taken = 1, upd_target = 0x80 -> mispredict = 1, redirect_pc = 0x80.
2. After scenario 1 (ctr = 2), lookup 0x40 -> pred_taken = 1, pred_npc = 0x80. Two not-taken updates -> ctr = 0, lookup gives 0x44. A third not-taken update keeps ctr at 0 (saturation).
3. Alias test, ENTRIES = 16: allocate 0x40 taken to 0x80, then upd_uncond for 0x440 to 0x900. Lookup 0x40 -> miss, pred_npc = 0x44. Lookup 0x440 -> pred_npc = 0x900.
4. Simultaneous update allocating 0x100 and lookup of 0x100 in the same cycle -> lookup gives 0x104. The next cycle gives the trained target.
5. flush_all together with upd_en for 0x200 -> all lookups miss afterwards. nRST pulsed mid-run -> pred_npc = lookup_pc+4 and mispredict = 0 immediately.
6. With BPRED_PERF_EN: 10 clocks containing 3 mispredicts -> perf_lookups = 10, perf_mispredicts = 3. Without the macro, both ports read 0.
